column_drawer: RTL

//   Rasterises one obstacle column (pipe with a vertical gap) into the VGA pixel stream, one pixel per clock.

---
 rtl/column_drawer.sv | 84 ++++++++
 1 files changed

// File: rtl/column_drawer.sv
// column_drawer: rasterises one pipe column plus its trailing erase strip,
// one registered pixel per clock, releasing the VGA bus via done_col when idle.
module column_drawer #(
   parameter int          SCREEN_W   = 160,
   parameter int          SCREEN_H   = 120,
   parameter int          COL_W      = 10,
   parameter int          GAP_H      = 40,
   parameter logic [2:0]  COL_COLOUR = 3'b010,
   parameter logic [2:0]  BG_COLOUR  = 3'b000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] col_x_in,
   input  logic [6:0] gap_y,
   output logic [7:0] col_x,
   output logic [6:0] col_y,
   output logic [2:0] col_colour,
   output logic       plot,
   output logic       done_col
);
   localparam int OW = $clog2(COL_W + 1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_DRAW = 1'b1;

   logic [0:0]    r_state;
   logic [7:0]    r_base;
   logic [6:0]    r_gtop;
   logic [OW-1:0] r_off;
   logic [6:0]    r_y;

   logic          w_idle;
   logic          w_last;
   logic          w_adv;
   logic          w_row_end;
   logic [7:0]    w_gsum;
   logic [7:0]    w_base;
   logic [6:0]    w_gtop;
   logic [OW-1:0] w_off;
   logic [6:0]    w_y;
   logic [8:0]    w_x;
   logic          w_gap;

   assign w_idle    = r_state == S_IDLE;
   assign w_row_end = r_off == OW'(COL_W);
   assign w_last    = w_row_end && r_y == 7'(SCREEN_H - 1);
   assign w_adv     = w_idle ? start : !w_last;
   assign w_gsum    = {1'b0, gap_y} + 8'(GAP_H);
   // In IDLE the next pixel is (col_x_in, 0) with a freshly clamped gap top.
   assign w_base    = w_idle ? col_x_in : r_base;
   assign w_gtop    = !w_idle ? r_gtop : (w_gsum > 8'(SCREEN_H)) ? 7'(SCREEN_H - GAP_H) : gap_y;
   assign w_off     = (w_idle || w_row_end) ? '0 : r_off + 1'b1;
   assign w_y       = w_idle ? '0 : w_row_end ? r_y + 1'b1 : r_y;
   assign w_x       = {1'b0, w_base} + 9'(w_off);
   assign w_gap     = {1'b0, w_y} >= {1'b0, w_gtop} && {1'b0, w_y} < {1'b0, w_gtop} + 8'(GAP_H);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_gtop     <= '0;
         r_off      <= '0;
         r_y        <= '0;
         col_x      <= '0;
         col_y      <= '0;
         col_colour <= BG_COLOUR;
         plot       <= 1'b0;
         done_col   <= 1'b1;
      end else begin
         r_state  <= w_adv ? S_DRAW : S_IDLE;
         done_col <= !w_adv;
         plot     <= w_adv && w_x < 9'(SCREEN_W);
         if (w_adv) begin
            r_base     <= w_base;
            r_gtop     <= w_gtop;
            r_off      <= w_off;
            r_y        <= w_y;
            col_x      <= w_x[7:0];
            col_y      <= w_y;
            col_colour <= (w_off == OW'(COL_W) || w_gap) ? BG_COLOUR : COL_COLOUR;
         end
      end
   end
endmodule
